// File: rtl/eq_pkg.sv
// Shared types, default widths and saturation helper for the equalizer band mixer.
package eq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      VOL,
      HOLD
   } eq_mix_state_t;

   localparam int DEF_NUM_CH    = 2;
   localparam int DEF_NUM_BANDS = 5;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_GAIN_W    = 12;
   localparam int DEF_VOL_W     = 12;

   // Clamp a sign-extended value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared signed-sample by unsigned-gain multiplier feeding a full-precision accumulator.
module eq_mac #(
   parameter int DATA_W    = 16,
   parameter int GAIN_W    = 12,
   parameter int NUM_BANDS = 5,
   parameter int ACC_W     = DATA_W + GAIN_W + 1 + $clog2(NUM_BANDS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] sample,
   input  logic        [GAIN_W-1:0] gain,
   output logic signed [ACC_W-1:0]  acc
);

   localparam int PROD_W = DATA_W + GAIN_W + 1;

   logic signed [PROD_W-1:0] sample_x;
   logic signed [PROD_W-1:0] gain_x;
   logic signed [PROD_W-1:0] product;

   // The gain is treated as a non-negative signed operand so one signed multiply suffices.
   assign sample_x = {{(GAIN_W + 1){sample[DATA_W-1]}}, sample};
   assign gain_x   = {{(DATA_W + 1){1'b0}}, gain};
   assign product  = sample_x * gain_x;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + ACC_W'(product);
      end
   end

endmodule

// File: rtl/eq_band_mixer.sv
// Time-multiplexed per-band gain, band sum and master volume stage with valid/ready framing.
module eq_band_mixer
   import eq_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int NUM_BANDS = DEF_NUM_BANDS,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int GAIN_W    = DEF_GAIN_W,
   parameter int VOL_W     = DEF_VOL_W
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]  bands_in,
   input  logic [NUM_BANDS*GAIN_W-1:0]         gains,
   input  logic [VOL_W-1:0]                    volume,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_CH*DATA_W-1:0]            samples_out,
   output logic                                busy
);

   localparam int ACC_W   = DATA_W + GAIN_W + 1 + $clog2(NUM_BANDS);
   localparam int VPROD_W = DATA_W + VOL_W + 1;
   localparam int BW      = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NS      = NUM_CH * NUM_BANDS;
   localparam int IW      = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [BW-1:0] LAST_B  = BW'(NUM_BANDS - 1);
   localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

   eq_mix_state_t state;
   eq_mix_state_t state_nx;

   logic [CW-1:0] ch;
   logic [BW-1:0] b;
   logic [IW-1:0] sel;

   logic signed [DATA_W-1:0] smp_q [NS];
   logic        [GAIN_W-1:0] gain_q [NUM_BANDS];
   logic        [VOL_W-1:0]  vol_q;

   logic accept;
   logic mac_en;
   logic acc_clr;

   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_shift;
   logic signed [DATA_W-1:0]  band_sum;
   logic signed [VPROD_W-1:0] sum_x;
   logic signed [VPROD_W-1:0] vol_x;
   logic signed [VPROD_W-1:0] vol_prod;
   logic signed [VPROD_W-1:0] vol_shift;
   logic signed [DATA_W-1:0]  vol_out;

   assign sel = IW'(ch) * IW'(NUM_BANDS) + IW'(b);

   eq_mac #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .NUM_BANDS (NUM_BANDS),
      .ACC_W     (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (acc_clr),
      .enable (mac_en),
      .sample (smp_q[sel]),
      .gain   (gain_q[b]),
      .acc    (acc)
   );

   // Band sum is rescaled and clamped before the volume multiply so the second product stays narrow.
   assign acc_shift = acc >>> (GAIN_W - 1);
   assign band_sum  = DATA_W'(sat(64'(acc_shift), DATA_W));
   assign sum_x     = {{(VOL_W + 1){band_sum[DATA_W-1]}}, band_sum};
   assign vol_x     = {{(DATA_W + 1){1'b0}}, vol_q};
   assign vol_prod  = sum_x * vol_x;
   assign vol_shift = vol_prod >>> (VOL_W - 1);
   assign vol_out   = DATA_W'(sat(64'(vol_shift), DATA_W));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      mac_en   = 1'b0;
      acc_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept   = 1'b1;
               acc_clr  = 1'b1;
               state_nx = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (b == LAST_B) begin
               state_nx = VOL;
            end
         end
         VOL: begin
            acc_clr  = 1'b1;
            state_nx = (ch == LAST_CH) ? HOLD : MAC;
         end
         HOLD: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Frame operands are captured once at accept so upstream may change freely mid-frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch          <= '0;
         b           <= '0;
         vol_q       <= '0;
         samples_out <= '0;
         for (int i = 0; i < NS; i++) begin
            smp_q[i] <= '0;
         end
         for (int i = 0; i < NUM_BANDS; i++) begin
            gain_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            ch    <= '0;
            b     <= '0;
            vol_q <= volume;
            for (int i = 0; i < NS; i++) begin
               smp_q[i] <= bands_in[i*DATA_W +: DATA_W];
            end
            for (int i = 0; i < NUM_BANDS; i++) begin
               gain_q[i] <= gains[i*GAIN_W +: GAIN_W];
            end
         end
         if (state == MAC && b != LAST_B) begin
            b <= b + 1'b1;
         end
         if (state == VOL) begin
            b <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
               if (ch == CW'(c)) begin
                  samples_out[c*DATA_W +: DATA_W] <= vol_out;
               end
            end
            if (ch != LAST_CH) begin
               ch <= ch + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Randomized and directed bench for eq_band_mixer against an arithmetic frame model.
module tb_eq_band_mixer;

   localparam int NC = 2;
   localparam int NB = 5;
   localparam int DW = 16;
   localparam int GW = 12;
   localparam int VW = 12;

   logic                  clk;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic [NC*NB*DW-1:0]   bands_in;
   logic [NB*GW-1:0]      gains;
   logic [VW-1:0]         volume;
   logic                  out_valid;
   logic                  out_ready;
   logic [NC*DW-1:0]      samples_out;
   logic                  busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc = 0;
   bit pending = 0;
   bit prev_ov = 0;
   logic [NC*DW-1:0] exp_q [$];

   logic [NC*NB*DW-1:0] bd;
   logic [NB*GW-1:0]    gn;
   logic [VW-1:0]       vl;

   eq_band_mixer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .bands_in    (bands_in),
      .gains       (gains),
      .volume      (volume),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .samples_out (samples_out),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic longint clamp(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Straight arithmetic: sum of sample*gain, floor-divide by gain unity, clamp, scale by volume, clamp.
   function automatic logic [NC*DW-1:0] model(input logic [NC*NB*DW-1:0] xb,
                                              input logic [NB*GW-1:0] xg,
                                              input logic [VW-1:0] xv);
      logic [NC*DW-1:0] r;
      logic signed [DW-1:0] x;
      longint acc;
      longint s;
      longint v;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         acc = 0;
         for (int k = 0; k < NB; k++) begin
            x = xb[(c*NB+k)*DW +: DW];
            acc = acc + longint'(x) * longint'(xg[k*GW +: GW]);
         end
         s = clamp(acc >>> (GW - 1));
         v = clamp((s * longint'(xv)) >>> (VW - 1));
         r[c*DW +: DW] = v[DW-1:0];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic randInputs(output logic [NC*NB*DW-1:0] xb,
                             output logic [NB*GW-1:0] xg,
                             output logic [VW-1:0] xv);
      logic [DW-1:0] t;
      for (int i = 0; i < NC*NB; i++) begin
         t = 16'($urandom);
         if ($urandom_range(0, 1) == 1) t = {{4{t[11]}}, t[11:0]};
         xb[i*DW +: DW] = t;
      end
      for (int i = 0; i < NB; i++) begin
         xg[i*GW +: GW] = 12'($urandom);
      end
      xv = 12'($urandom);
   endtask

   // Compare process: checks handshake invariants every cycle and frame contents whenever valid.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (!rst_n) begin
            exp_q.delete();
            pending = 0;
            prev_ov = 0;
         end else begin
            check("ready_vs_busy", 32'(in_ready), 32'(!busy));
            check("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            if (pending && cyc == acc_cyc + 7 && exp_q.size() > 0)
               check("ch0_written", 32'(samples_out[DW-1:0]), 32'(exp_q[$][DW-1:0]));
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("[TB] FAIL valid_has_frame: got out_valid=1, required no frame pending");
               end else begin
                  check("frame", samples_out, exp_q[0]);
               end
               if (!prev_ov && pending) begin
                  check("latency", 32'(cyc - acc_cyc - 1), 32'd12);
                  pending = 0;
               end
               if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(model(bands_in, gains, volume));
               acc_cyc = cyc;
               pending = 1;
            end
            prev_ov = out_valid;
         end
      end
   end

   task automatic applyStimulus(input logic [NC*NB*DW-1:0] xb,
                                input logic [NB*GW-1:0] xg,
                                input logic [VW-1:0] xv);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      bands_in = xb;
      gains    = xg;
      volume   = xv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitOutput(input bit scramble);
      int t = 0;
      logic [NC*NB*DW-1:0] rb;
      logic [NB*GW-1:0]    rg;
      logic [VW-1:0]       rv;
      while (!out_valid && t < 100) begin
         if (scramble) begin
            randInputs(rb, rg, rv);
            bands_in = rb;
            gains    = rg;
            volume   = rv;
         end
         @(negedge clk);
         t++;
      end
      check("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic checkOutput(input string name, input logic [NC*DW-1:0] req);
      check(name, samples_out, req);
   endtask

   task automatic releaseOutput(input int hold, input bit probe);
      logic [NC*DW-1:0]    snap;
      logic [NC*NB*DW-1:0] rb;
      logic [NB*GW-1:0]    rg;
      logic [VW-1:0]       rv;
      snap = samples_out;
      for (int i = 0; i < hold; i++) begin
         if (probe) begin
            randInputs(rb, rg, rv);
            bands_in = rb;
            gains    = rg;
            volume   = rv;
            in_valid = 1'b1;
         end
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_stable", samples_out, snap);
         check("hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
      if (probe) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bands_in  = '0;
      gains     = '0;
      volume    = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_samples", samples_out, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      $display("[TB] unity path");
      applyStimulus({{5{16'hF000}}, {5{16'h1000}}}, {5{12'h800}}, 12'h800);
      waitOutput(0);
      checkOutput("unity", 32'hB000_5000);
      releaseOutput(2, 0);

      $display("[TB] saturation");
      applyStimulus({{5{16'h8000}}, {5{16'h2000}}}, {5{12'h800}}, 12'h800);
      waitOutput(0);
      checkOutput("saturate", 32'h8000_7FFF);
      releaseOutput(0, 0);

      $display("[TB] gain range");
      bd = {{4{16'h0000}}, 16'h1000, {4{16'h0000}}, 16'h1000};
      applyStimulus(bd, {{4{12'h800}}, 12'h000}, 12'h800);
      waitOutput(0);
      checkOutput("gain_zero", 32'h0000_0000);
      releaseOutput(0, 0);
      applyStimulus(bd, {{4{12'h800}}, 12'hFFF}, 12'h800);
      waitOutput(0);
      checkOutput("gain_max", 32'h1FFE_1FFE);
      releaseOutput(0, 0);
      applyStimulus(bd, {5{12'h800}}, 12'h400);
      waitOutput(0);
      checkOutput("half_volume", 32'h0800_0800);
      releaseOutput(0, 0);

      $display("[TB] handshake hold with ignored in_valid");
      applyStimulus({{5{16'hF000}}, {5{16'h1000}}}, {5{12'h800}}, 12'h800);
      waitOutput(0);
      checkOutput("hold_unity", 32'hB000_5000);
      releaseOutput(20, 1);
      waitOutput(0);
      releaseOutput(1, 0);

      $display("[TB] input latching");
      randInputs(bd, gn, vl);
      applyStimulus(bd, gn, vl);
      waitOutput(1);
      checkOutput("latched", model(bd, gn, vl));
      releaseOutput(0, 0);

      $display("[TB] reset mid-frame");
      randInputs(bd, gn, vl);
      applyStimulus(bd, gn, vl);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_samples", samples_out, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus({{5{16'hF000}}, {5{16'h1000}}}, {5{12'h800}}, 12'h800);
      waitOutput(0);
      checkOutput("post_reset", 32'hB000_5000);
      releaseOutput(0, 0);

      $display("[TB] random frames");
      for (int n = 0; n < 40; n++) begin
         randInputs(bd, gn, vl);
         applyStimulus(bd, gn, vl);
         waitOutput(1'($urandom_range(0, 1)));
         releaseOutput($urandom_range(0, 3), 0);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Parametrised, time-multiplexed band gain/sum/volume stage for the equalizer datapath, the generalised successor of the fixed 2-channel, 5-band scaling network. It takes one frame of band-filter outputs for NUM_CH channels, scales each band by its gain with a single shared multiplier, and accumulates the scaled bands at full precision. It then applies master volume, saturates to DATA_W, and presents the frame on a valid/ready output. It sits between the band filters and the codec/I2S output path.

## Interface
- NUM_CH, 2, audio channels per frame (ch0 = left, ch1 = right)
- NUM_BANDS, 5, bands per channel
- DATA_W, 16, signed sample width
- GAIN_W, 12, unsigned band gain width; unity = 2^(GAIN_W-1)
- VOL_W, 12, unsigned volume width; unity = 2^(VOL_W-1)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  frame available on bands_in
- in_ready  out  1  block can accept a frame
- bands_in  in  NUM_CH*NUM_BANDS*DATA_W  signed samples; slice [ch*NUM_BANDS+b]
- gains  in  NUM_BANDS*GAIN_W  per-band gain, shared by all channels; slice [b]
- volume  in  VOL_W  master volume
- out_valid  out  1  result frame valid
- out_ready  in  1  downstream accepts result
- samples_out  out  NUM_CH*DATA_W  signed results; slice [ch]
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MAC, VOL, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, latch bands_in, gains and volume, clear the accumulator, set ch=0 and b=0, and go to MAC. in_valid outside IDLE is ignored and nothing is latched.
- MAC: one product per cycle, acc += sample[ch][b] * $signed({1'b0,gain[b]}). acc width = DATA_W+GAIN_W+1+$clog2(NUM_BANDS) and never overflows. After b = NUM_BANDS-1, go to VOL.
- VOL, one cycle: s = sat_DATA_W(acc >>> (GAIN_W-1)), then v = sat_DATA_W((s * $signed({1'b0,volume})) >>> (VOL_W-1)), written to samples_out[ch]. Clear acc and b. If ch < NUM_CH-1, increment ch and go to MAC. Otherwise set out_valid and go to HOLD.
- Shifts are arithmetic and truncate toward −inf; no rounding.
- Saturation clamps to 2^(DATA_W-1)-1 and −2^(DATA_W-1).
- HOLD: out_valid=1, and samples_out is stable until out_ready. On out_ready, clear out_valid and go to IDLE.
- samples_out is updated only in VOL. Between frames it holds its last value.
- Latched gains/volume are used for the whole frame. Input changes mid-frame have no effect.
- Reset (async, any state): state=IDLE, acc=0, ch=b=0, out_valid=0, samples_out=0, busy=0. in_ready is 1 immediately after reset. A frame in flight is discarded.

## Timing
- Accept at edge k, then out_valid rises after edge k + NUM_CH*(NUM_BANDS+1). Defaults give 12 cycles.
- samples_out[ch] is written at edge k + (ch+1)*(NUM_BANDS+1).
- Throughput: with out_ready held high, frames can be accepted every NUM_CH*(NUM_BANDS+1)+2 cycles. HOLD→IDLE takes 1 cycle; IDLE→accept takes 1 cycle.
- in_ready and out_valid are never high together.
- out_ready while out_valid=0 is ignored.
- The multiplier path is registered (acc). In VOL, the saturate→volume multiply→saturate chain must close timing at the system clock. If it does not, split VOL into two cycles and raise latency by NUM_CH; that change needs spec revision.

## Structure
- Package eq_pkg holds:
  - state enum eq_mix_state_t {IDLE, MAC, VOL, HOLD}
  - default width localparams
  - a sat function parametrised by width
- Sub-module eq_mac: the shared signed×unsigned multiplier plus accumulator, with clear/enable inputs. The FSM, indexing and output registers stay in eq_band_mixer.

## Test plan
All tests use defaults, all gains 0x800 and volume 0x800 unless stated.
- Unity path: ch0 bands all 0x1000 → samples_out[0]=0x5000. ch1 bands all 0xF000 (−0x1000) → 0xB000. out_valid exactly 12 cycles after accept.
- Saturation: ch0 bands all 0x2000 → 0x7FFF. ch1 bands all 0x8000 → 0x8000.
- Gain range: band0=0x1000, others 0. gains[0]=0x000 → 0x0000. gains[0]=0xFFF → 0x1FFE. gains[0]=0x800 with volume=0x400 → 0x0800.
- Handshake: hold out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0, and a new in_valid is ignored. Pulse out_ready → IDLE next cycle. The second frame is accepted and correct.
- Input latching: change gains, volume and bands_in every cycle during MAC → result equals the values latched at accept.
- Reset mid-frame: assert rst_n=0 at cycle 5 of a frame → out_valid=0, samples_out=0 and busy=0 immediately. After release, a fresh frame produces correct results with no residue.
